// File: rtl/pc_trace_buf.sv
// Circular trace buffer for the execute-stage PC: records PC changes, freezes
// a programmable number of samples after a trigger, then drains oldest-first.
//
// state | meaning
// IDLE  | cleared, waiting for trc_en
// RUN   | capturing, waiting for trig
// POST  | capturing, pcnt samples left before freezing
// HOLD  | frozen, buffer readable over rd_*
module pc_trace_buf #(
    parameter int AW   = 4,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] ie_pc,
    input  logic            ie_pc_vld,
    input  logic            trc_en,
    input  logic            trc_clr,
    input  logic            trig,
    input  logic [7:0]      post_cnt,
    output logic            rd_vld,
    input  logic            rd_rdy,
    output logic [PC_W-1:0] rd_data,
    output logic [AW:0]     trc_cnt,
    output logic            trc_ovf,
    output logic [1:0]      trc_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      pcnt_q, pcnt_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            first_q, first_d;

    logic [PC_W-1:0] mem [DEPTH];

    logic capturing;
    logic qual;
    logic xfer;

    assign capturing = ((state_q == RUN) || (state_q == POST)) && trc_en && !trc_clr;
    assign qual      = capturing && ie_pc_vld && (first_q || (ie_pc != last_pc_q));
    assign rd_vld    = (state_q == HOLD) && (cnt_q != '0);
    assign xfer      = rd_vld && rd_rdy && !trc_clr;
    assign rd_data   = mem[rd_ptr_q];
    assign trc_cnt   = cnt_q;
    assign trc_ovf   = ovf_q;
    assign trc_state = state_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        pcnt_d    = pcnt_q;
        last_pc_d = last_pc_q;
        first_d   = first_q;

        if (qual) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            last_pc_d = ie_pc;
            first_d   = 1'b0;
            // When full, the oldest entry is overwritten so the read side moves too.
            if (cnt_q == FULL_CNT) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                ovf_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trc_en) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end
            end
            RUN: begin
                if (!trc_en) begin
                    state_d = HOLD;
                end else if (trig) begin
                    if (post_cnt == 8'd0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = POST;
                        pcnt_d  = post_cnt;
                    end
                end
            end
            POST: begin
                if (!trc_en) begin
                    state_d = HOLD;
                end else if (qual) begin
                    pcnt_d = pcnt_q - 8'd1;
                    if (pcnt_q == 8'd1) state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase

        if (trc_clr) begin
            state_d   = IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            pcnt_d    = '0;
            last_pc_d = '0;
            first_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            pcnt_q    <= '0;
            last_pc_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            pcnt_q    <= pcnt_d;
            last_pc_q <= last_pc_d;
            first_q   <= first_d;
        end
    end

    // Storage is intentionally not reset; rd_data is only meaningful with rd_vld.
    always_ff @(posedge clk) begin
        if (qual) mem[wr_ptr_q] <= ie_pc;
    end

endmodule

// File: tb/tb_pc_trace_buf.sv
// Directed bench for pc_trace_buf: expected drain data goes into a scoreboard
// queue, a negedge monitor pops and compares every accepted read.
module tb_pc_trace_buf;

    localparam int AW   = 4;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] ie_pc = '0;
    logic            ie_pc_vld = 1'b0;
    logic            trc_en = 1'b0;
    logic            trc_clr = 1'b0;
    logic            trig = 1'b0;
    logic [7:0]      post_cnt = '0;
    logic            rd_vld;
    logic            rd_rdy = 1'b0;
    logic [PC_W-1:0] rd_data;
    logic [AW:0]     trc_cnt;
    logic            trc_ovf;
    logic [1:0]      trc_state;

    int n_chk  = 0;
    int n_fail = 0;
    logic [PC_W-1:0] sb[$];

    pc_trace_buf #(.AW(AW), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ie_pc     (ie_pc),
        .ie_pc_vld (ie_pc_vld),
        .trc_en    (trc_en),
        .trc_clr   (trc_clr),
        .trig      (trig),
        .post_cnt  (post_cnt),
        .rd_vld    (rd_vld),
        .rd_rdy    (rd_rdy),
        .rd_data   (rd_data),
        .trc_cnt   (trc_cnt),
        .trc_ovf   (trc_ovf),
        .trc_state (trc_state)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted read must match the oldest expected PC.
    always @(negedge clk) begin
        if (!rst && rd_vld && rd_rdy && !trc_clr) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h, no entry expected", rd_data);
            end else begin
                logic [PC_W-1:0] exp_pc;
                exp_pc = sb.pop_front();
                if (rd_data !== exp_pc) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, expected %h", rd_data, exp_pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        int n;
        rd_rdy = 1'b1;
        n = 0;
        while (rd_vld && n < 40) begin
            tick();
            n++;
        end
        rd_rdy = 1'b0;
        chk({name, "_drain_done"}, {31'd0, rd_vld}, 32'd0);
        chk({name, "_sb_left"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic clear_and_run();
        trc_clr = 1'b1;
        tick();
        trc_clr = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_state", trc_state, 0);
        chk("rst_cnt", trc_cnt, 0);
        chk("rst_ovf", trc_ovf, 0);
        chk("rst_vld", rd_vld, 0);
        rst = 1'b0;
        tick();

        // Basic capture with repeated PC and post_cnt=0 trigger
        trc_en = 1'b1;
        tick();
        chk("en_run", trc_state, 1);
        ie_pc_vld = 1'b1;
        ie_pc = 32'h100; tick();
        ie_pc = 32'h100; tick();
        ie_pc = 32'h104; tick();
        ie_pc = 32'h108; tick();
        trig = 1'b1; post_cnt = 8'd0; tick();
        trig = 1'b0;
        chk("t1_cnt", trc_cnt, 3);
        chk("t1_hold", trc_state, 3);
        chk("t1_vld", rd_vld, 1);
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        drain("t1");
        chk("t1_cnt_empty", trc_cnt, 0);

        // Overflow: 20 distinct PCs into 16 entries, manual freeze
        trc_clr = 1'b1; tick(); trc_clr = 1'b0;
        chk("t2_idle", trc_state, 0);
        tick();
        chk("t2_run", trc_state, 1);
        for (int i = 0; i < 20; i++) begin
            ie_pc = 32'(i * 4);
            tick();
        end
        trc_en = 1'b0; tick();
        chk("t2_cnt", trc_cnt, 16);
        chk("t2_ovf", trc_ovf, 1);
        chk("t2_hold", trc_state, 3);
        for (int i = 4; i < 20; i++) sb.push_back(32'(i * 4));
        drain("t2");
        chk("t2_ovf_sticky", trc_ovf, 1);

        // Post-trigger count of 3, repeated trig in POST ignored
        trc_en = 1'b1;
        clear_and_run();
        chk("t3_ovf_clr", trc_ovf, 0);
        ie_pc = 32'h200; tick();
        ie_pc = 32'h204; trig = 1'b1; post_cnt = 8'd3; tick();
        chk("t3_post", trc_state, 2);
        chk("t3_cnt_trig", trc_cnt, 2);
        ie_pc = 32'h208; trig = 1'b1; post_cnt = 8'd0; tick();
        trig = 1'b0;
        chk("t3_post_again", trc_state, 2);
        ie_pc = 32'h20C; tick();
        chk("t3_still_post", trc_state, 2);
        ie_pc = 32'h210; tick();
        chk("t3_hold", trc_state, 3);
        ie_pc = 32'h214; tick();
        ie_pc = 32'h218; tick();
        chk("t3_cnt", trc_cnt, 5);
        sb.push_back(32'h200); sb.push_back(32'h204); sb.push_back(32'h208);
        sb.push_back(32'h20C); sb.push_back(32'h210);
        drain("t3");

        // Invalid cycles and constant PC
        clear_and_run();
        ie_pc_vld = 1'b0;
        ie_pc = 32'h300; tick();
        ie_pc = 32'h304; tick();
        ie_pc = 32'h308; tick();
        chk("t4_novld_cnt", trc_cnt, 0);
        ie_pc_vld = 1'b1; ie_pc = 32'h400;
        repeat (4) tick();
        chk("t4_const_cnt", trc_cnt, 1);
        trig = 1'b1; post_cnt = 8'd0; tick();
        trig = 1'b0;
        sb.push_back(32'h400);
        drain("t4");

        // Clear in the middle of a drain, then first-sample capture
        clear_and_run();
        for (int i = 0; i < 4; i++) begin
            ie_pc = 32'h500 + 32'(i * 4);
            tick();
        end
        trig = 1'b1; tick(); trig = 1'b0;
        chk("t5_cnt", trc_cnt, 4);
        sb.push_back(32'h500); sb.push_back(32'h504);
        rd_rdy = 1'b1;
        tick(); tick();
        chk("t5_half_cnt", trc_cnt, 2);
        trc_clr = 1'b1; ie_pc = 32'h0; tick();
        trc_clr = 1'b0; rd_rdy = 1'b0;
        chk("t5_clr_cnt", trc_cnt, 0);
        chk("t5_clr_ovf", trc_ovf, 0);
        chk("t5_clr_state", trc_state, 0);
        chk("t5_clr_vld", rd_vld, 0);
        chk("t5_sb_left", sb.size(), 0);
        tick();
        chk("t5_rerun", trc_state, 1);
        tick(); tick();
        chk("t5_first_cnt", trc_cnt, 1);

        // Asynchronous reset in the middle of POST
        ie_pc = 32'h600; trig = 1'b1; post_cnt = 8'd5; tick();
        trig = 1'b0;
        ie_pc = 32'h604; tick();
        chk("t6_post", trc_state, 2);
        chk("t6_cnt", trc_cnt, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", trc_state, 0);
        chk("t6_rst_cnt", trc_cnt, 0);
        chk("t6_rst_ovf", trc_ovf, 0);
        chk("t6_rst_vld", rd_vld, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_run", trc_state, 1);

        chk("final_sb", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_trace_buf.md
# pc_trace_buf

Synthesizable on-chip trace buffer for the execute-stage program counter (`ie_pc`) of the M0 core.
- Records every change of the qualified IE PC into a circular buffer.
- Freezes after a programmable number of post-trigger samples.
- Drains captured PCs oldest-first over a valid/ready port.

It is the hardware counterpart of the simulation PC log. It sits beside `inst_exe` in `inst_unit` and consumes the same `ie_pc` signal, so the PC history is available on silicon through the debug bus.

## Interface
Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.

Parameters:
- `AW`, default 4: address width; buffer depth is 2^AW entries.
- `PC_W`, default 32: width of a stored PC.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous active-high reset
- `ie_pc`  in  PC_W  execute-stage PC
- `ie_pc_vld`  in  1  `ie_pc` is meaningful this cycle (stage not stalled or flushed)
- `trc_en`  in  1  level; arms and keeps capture running
- `trc_clr`  in  1  pulse; empties the buffer and returns to IDLE
- `trig`  in  1  pulse; trigger event
- `post_cnt`  in  8  number of samples to capture after the trigger; sampled at the trigger
- `rd_vld`  out  1  `rd_data` holds an unread entry
- `rd_rdy`  in  1  consumer accepts `rd_data`
- `rd_data`  out  PC_W  oldest unread PC
- `trc_cnt`  out  AW+1  number of entries held (0..2^AW)
- `trc_ovf`  out  1  sticky; at least one entry was overwritten
- `trc_state`  out  2  0=IDLE, 1=RUN, 2=POST, 3=HOLD

## Operation
Sample qualification:
- A sample qualifies when the state is RUN or POST, `ie_pc_vld`=1, and either `ie_pc` differs from `last_pc` or `first`=1.
- `first` is set on entry to RUN from IDLE and cleared by the first qualifying sample.
- `last_pc` updates on every qualifying sample.

Write path:
- Write at `wr_ptr`, then `wr_ptr`+1 (mod 2^AW).
- If `trc_cnt` is not full, increment `trc_cnt`.
- If full: also advance `rd_ptr` (the oldest entry is overwritten), hold `trc_cnt` at 2^AW, and set `trc_ovf`.

State machine:
- IDLE → RUN when `trc_en`=1.
- RUN → POST on `trig`=1 with `post_cnt`≠0. `pcnt` loads `post_cnt`. A sample qualifying in the trigger cycle is stored but not counted against `pcnt`.
- RUN → HOLD on `trig`=1 with `post_cnt`=0. The trigger-cycle sample is still stored.
- POST: each qualifying sample decrements `pcnt`. The sample that takes `pcnt` from 1 to 0 is stored, and the state moves to HOLD.
- RUN or POST → HOLD when `trc_en`=0 (manual freeze). No capture happens in that cycle.
- HOLD: no capture. Leaves only via `trc_clr`.
- Any state → IDLE on `trc_clr`=1. `trc_clr` has priority over `trig`, `trc_en` and reads. It zeroes `wr_ptr`, `rd_ptr`, `trc_cnt`, `trc_ovf`, `pcnt`, `last_pc` and `first`. Buffer contents are not cleared.
- `trig` in IDLE or HOLD is ignored. A repeated `trig` in POST is ignored.

Read path:
- `rd_vld` = (state is HOLD) and (`trc_cnt`≠0).
- `rd_data` = `mem[rd_ptr]`, combinational from the register array.
- A transfer happens when `rd_vld` and `rd_rdy` are both 1: `rd_ptr` increments and `trc_cnt` decrements.
- Reads are impossible outside HOLD, so reads and writes never coincide.

Reset values: `trc_state`=0, `trc_cnt`=0, `trc_ovf`=0, `rd_vld`=0, `rd_data`=`mem[0]`. `rd_data` is don't-care while `rd_vld`=0, and the memory array is not reset.

## Timing
- Capture: a qualifying sample in cycle N appears in `trc_cnt` and the memory at the N+1 edge.
- State transitions take effect at the edge after the causing input. `trc_state` and `rd_vld` are registered-state derived.
- Readout: first `rd_vld` is in the cycle after HOLD is entered, if `trc_cnt`≠0. Throughput is one entry per cycle with `rd_rdy` held high.
- Wrap-around: pointers wrap silently. In the overwrite cycle, `rd_ptr` and `wr_ptr` advance together.
- Asynchronous `rst` in mid-capture or mid-read: all registers listed under reset values clear immediately, and no partial transfer is reported.

## Test plan
- Enable with AW=4. Drive `ie_pc` 0x100, 0x100, 0x104, 0x108 with `ie_pc_vld`=1, then pulse `trig` with `post_cnt`=0 → `trc_cnt`=3, HOLD. Drain yields 0x100, 0x104, 0x108, then `rd_vld`=0.
- Feed 20 distinct PCs 0x0..0x4C (step 4), then `trc_en`=0 → `trc_cnt`=16, `trc_ovf`=1. Drain yields 0x10..0x4C in order.
- `trig` with `post_cnt`=3 while 5 more distinct PCs arrive → exactly 3 stored after the trigger-cycle sample; state goes to HOLD after the third.
- Toggle `ie_pc_vld` low while `ie_pc` changes → no capture. Hold `ie_pc` constant and valid → one entry only.
- Halfway through a drain, pulse `trc_clr` together with `rd_rdy` → `trc_cnt`=0, `trc_ovf`=0, IDLE. Re-enable → first sample captured even if equal to the previous `last_pc`.
- Assert `rst` mid-POST → all outputs at reset values in the same cycle. After release with `trc_en`=1, RUN is entered on the next edge.
